// File: rtl/egg_param_loader.sv
// Board input stage for the egg-drop CPU: synchronises and debounces the switches and buttons,
// latches the eggs/floor parameters and releases the CPU from reset on a valid start press.
module egg_param_loader #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 16
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [7:0]  choose,
  input  logic        id,
  input  logic        yes,
  input  logic        ready,
  output logic [31:0] eggs,
  output logic [31:0] floor,
  output logic [31:0] preview,
  output logic        working,
  output logic        cpu_reset,
  output logic        start,
  output logic        err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       r_chooseS1, r_chooseS2;
  logic             r_idS1, r_idS2;
  logic             r_yesS1, r_yesS2;
  logic             r_readyS1, r_readyS2;

  logic [CNT_W-1:0] r_yesCnt, r_readyCnt;
  logic             r_yesDb, r_readyDb;
  logic             r_yesDly, r_readyDly;

  state_t           r_state, w_stateNxt;
  logic [31:0]      r_eggs, r_floor;
  logic [31:0]      w_eggsNxt, w_floorNxt;
  logic             r_err, w_errNxt;
  logic             r_start, w_startNxt;
  logic             r_working, r_cpuReset;

  logic             w_commit, w_go;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_chooseS1 <= '0;
      r_chooseS2 <= '0;
      r_idS1     <= 1'b0;
      r_idS2     <= 1'b0;
      r_yesS1    <= 1'b0;
      r_yesS2    <= 1'b0;
      r_readyS1  <= 1'b0;
      r_readyS2  <= 1'b0;
    end else begin
      r_chooseS1 <= choose;
      r_chooseS2 <= r_chooseS1;
      r_idS1     <= id;
      r_idS2     <= r_idS1;
      r_yesS1    <= yes;
      r_yesS2    <= r_yesS1;
      r_readyS1  <= ready;
      r_readyS2  <= r_readyS1;
    end
  end

  // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle, hence the compare against N-1.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_yesCnt <= '0;
      r_yesDb  <= 1'b0;
    end else if (r_yesS2 == r_yesDb) begin
      r_yesCnt <= '0;
    end else if (r_yesCnt == LP_CNT_LAST) begin
      r_yesDb  <= r_yesS2;
      r_yesCnt <= '0;
    end else begin
      r_yesCnt <= r_yesCnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_readyCnt <= '0;
      r_readyDb  <= 1'b0;
    end else if (r_readyS2 == r_readyDb) begin
      r_readyCnt <= '0;
    end else if (r_readyCnt == LP_CNT_LAST) begin
      r_readyDb  <= r_readyS2;
      r_readyCnt <= '0;
    end else begin
      r_readyCnt <= r_readyCnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_yesDly   <= 1'b0;
      r_readyDly <= 1'b0;
    end else begin
      r_yesDly   <= r_yesDb;
      r_readyDly <= r_readyDb;
    end
  end

  assign w_commit = r_yesDb & ~r_yesDly;
  assign w_go     = r_readyDb & ~r_readyDly;

  // A start press takes priority over a simultaneous commit and is judged on the existing parameters.
  always_comb begin
    w_stateNxt = r_state;
    w_eggsNxt  = r_eggs;
    w_floorNxt = r_floor;
    w_errNxt   = r_err;
    w_startNxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          if ((r_eggs != 32'd0) && (r_floor != 32'd0)) begin
            w_stateNxt = ST_RUN;
            w_startNxt = 1'b1;
            w_errNxt   = 1'b0;
          end else begin
            w_errNxt = 1'b1;
          end
        end else if (w_commit) begin
          if (r_idS2) begin
            w_floorNxt = {24'b0, r_chooseS2};
          end else begin
            w_eggsNxt = {24'b0, r_chooseS2};
          end
          w_errNxt = 1'b0;
        end
      end
      ST_RUN: begin
        w_stateNxt = ST_RUN;
      end
      default: begin
        w_stateNxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_eggs     <= '0;
      r_floor    <= '0;
      r_err      <= 1'b0;
      r_start    <= 1'b0;
      r_working  <= 1'b0;
      r_cpuReset <= 1'b1;
    end else begin
      r_state    <= w_stateNxt;
      r_eggs     <= w_eggsNxt;
      r_floor    <= w_floorNxt;
      r_err      <= w_errNxt;
      r_start    <= w_startNxt;
      r_working  <= (w_stateNxt == ST_RUN);
      r_cpuReset <= (w_stateNxt != ST_RUN);
    end
  end

  assign eggs      = r_eggs;
  assign floor     = r_floor;
  assign err       = r_err;
  assign start     = r_start;
  assign working   = r_working;
  assign cpu_reset = r_cpuReset;
  assign preview   = (r_state == ST_IDLE) ? (r_idS2 ? r_floor : r_eggs) : 32'd0;

endmodule

// File: doc/egg_param_loader.md
# egg_param_loader

Front-end input stage for the egg-drop pipelined CPU board build. It synchronises and debounces the board switches and buttons, and latches the `eggs` and `floor` problem parameters into clean registers. On the debounced `ready` press it enters a run state and releases the CPU from reset. It sits between the raw board pins and the `pcpu_board` core; it replaces ad-hoc combinational parameter capture with a registered, glitch-free load/run sequence.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 20000: consecutive stable `clk_in` cycles required before a button's debounced level changes.
- `CNT_W`, default 16: debounce counter width; must hold `DEBOUNCE_CYCLES`.

Ports:
- `clk_in`, input, 1: board clock; the only clock.
- `reset`, input, 1: asynchronous, active-low; 0 clears all state.
- `choose`, input, 8: raw value switches, 0–255.
- `id`, input, 1: raw target select; 0 = eggs, 1 = floor.
- `yes`, input, 1: raw commit button.
- `ready`, input, 1: raw start button.
- `eggs`, output, 32: committed egg count, zero-extended.
- `floor`, output, 32: committed floor count, zero-extended.
- `preview`, output, 32: in IDLE, the committed value selected by `id`; in RUN, 0.
- `working`, output, 1: 1 in RUN.
- `cpu_reset`, output, 1: active-high reset to the CPU core; 1 in IDLE, 0 in RUN.
- `start`, output, 1: single-cycle pulse on the IDLE→RUN transition.
- `err`, output, 1: start was refused because `eggs` or `floor` was zero.

## Operation
- **Synchronisers:** `choose`, `id`, `yes` and `ready` each pass through a 2-flop synchroniser. Only synchronised values are used downstream.
- **Debounce (`yes`, `ready` each):**
  - Keep a counter and a debounced level.
  - Counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments each cycle.
  - When it reaches `DEBOUNCE_CYCLES`, the debounced level takes the synced level and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles has no effect.
- **Edge detect:**
  - `commit` = debounced `yes` high and its 1-cycle-delayed copy low.
  - `go` is formed the same way from debounced `ready`.
  - Falling edges are ignored.
- **FSM, 2 states:**
  - IDLE (reset state):
    - On `commit` with `go` low: if synced `id`=0, then `eggs` ← {24'b0, synced `choose`}; otherwise `floor` ← that value. `err` clears. The FSM stays in IDLE.
    - On `go`: if `eggs`≠0 and `floor`≠0, go to RUN, pulse `start` and clear `err`. Otherwise stay in IDLE with `err` ← 1.
    - `commit` and `go` in the same cycle: `go` wins; the commit is discarded and `go` is evaluated on the pre-existing registers.
  - RUN: `commit` and `go` are ignored; `eggs` and `floor` are frozen. RUN is left only by `reset`=0.
- **Re-commit:** a later commit to the same target overwrites the previous value.
- **Outputs:** all outputs are registered except `preview`, which is a mux of the registered values on the synced `id`.

## Timing
- **Reset values (`reset`=0, asynchronous):** `eggs`=0, `floor`=0, `working`=0, `cpu_reset`=1, `start`=0, `err`=0, `preview`=0. Synchronisers, debounced levels and counters are all cleared, and the FSM is in IDLE.
- **Reset mid-RUN:** immediately forces all of the above. The CPU is held in reset, and the parameters must be re-entered.
- **Latency, raw `yes` rise to register update (clean pulse):**
  - 2 cycles of synchronisation.
  - `DEBOUNCE_CYCLES` cycles to update the debounced level.
  - 1 further edge to update `eggs`/`floor`.
  - Total: `DEBOUNCE_CYCLES`+3 `clk_in` edges.
- **Latency, raw `ready` rise (clean pulse) to RUN:** `working`=1, `cpu_reset`=0 and `start`=1 all appear at the same edge, `DEBOUNCE_CYCLES`+3 edges after the rise. `start` deasserts at the next edge.
- **Sampling of `choose` and `id`:** both are sampled on the synced value at the update edge. Switches must therefore be stable for 2 cycles before the commit edge.
- **Release deassertion:** `cpu_reset` deasserts synchronously to `clk_in`. The CPU therefore sees `eggs`/`floor` stable for at least one full cycle before release.
- **Held buttons:** a held button produces exactly one `commit`/`go`. A new edge requires a debounced release followed by a press.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4.
1. **Reset values:** hold `reset`=0 with random inputs → all outputs at their reset values. Release → no change for 20 cycles.
2. **Commit both parameters:** `id`=0, `choose`=8'd2, `yes` high 10 cycles → `eggs`=2 exactly 7 edges after the rise. Then `id`=1, `choose`=8'd100, `yes` pulse → `floor`=100, `eggs` still 2, `preview`=100.
3. **Bounce rejection:** `yes` toggled every 2 cycles for 20 cycles, then low → `eggs` unchanged and no commit.
4. **Refused start:** after reset, commit `eggs`=3 only, then pulse `ready` → `err`=1, `working`=0, `cpu_reset`=1. Commit `floor`=36 → `err`=0. Pulse `ready` → `start` high for 1 cycle, then `working`=1 and `cpu_reset`=0.
5. **RUN freeze:** in RUN, `id`=0, `choose`=8'd9, `yes` pulse → `eggs` unchanged and `preview`=0.
6. **Simultaneous edges and mid-RUN reset:**
   - With `eggs`=2 and `floor`=10, raise `yes` (`choose`=8'd0, `id`=0) and `ready` on the same cycle → RUN entered, `eggs` stays 2.
   - Pulse `reset`=0 mid-RUN → immediate IDLE, `eggs`=`floor`=0, `cpu_reset`=1.
